// File: rtl/multi_button_debouncer_if.sv
// rtl/multi_button_debouncer_if.sv - button pins and debounced level/event bundle
interface multi_button_debouncer_if #(
    parameter int N = 4
);
    logic [N-1:0] b_in;
    logic [N-1:0] b_level;
    logic [N-1:0] b_press;
    logic [N-1:0] b_release;
    logic [N-1:0] b_long;
    logic [N-1:0] b_repeat;
    logic         any_pressed;

    modport master (
        output b_in,
        input  b_level, b_press, b_release, b_long, b_repeat, any_pressed
    );

    modport slave (
        input  b_in,
        output b_level, b_press, b_release, b_long, b_repeat, any_pressed
    );
endinterface

// File: rtl/multi_button_debouncer.sv
// rtl/multi_button_debouncer.sv - N-channel button debouncer with press/release/long events
// Auto-repeat pulses are built only when MULTI_BUTTON_DEBOUNCER_AUTOREPEAT_EN is defined.
module multi_button_debouncer #(
    parameter int N_BUTTONS     = 4,
    parameter int STABLE_CYCLES = 240000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 1200000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_button_debouncer_if.slave bus
);
    localparam int   DW  = $clog2(STABLE_CYCLES + 1);
    localparam int   HW  = $clog2(LONG_CYCLES + 1);
    localparam logic INV = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] D_TERM = DW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_TERM = HW'(LONG_CYCLES - 1);
`ifdef MULTI_BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int   RW  = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] R_TERM = RW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } state_t;

    logic [N_BUTTONS-1:0] level_w;
    logic [N_BUTTONS-1:0] press_w;
    logic [N_BUTTONS-1:0] release_w;
    logic [N_BUTTONS-1:0] long_w;
    logic [N_BUTTONS-1:0] repeat_w;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        logic          sync1_q, sync2_q, s;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic          level_q, level_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        state_t        state_q, state_d;
        logic          press_c, release_c, long_c, repeat_c;

        // Synchroniser resets to the pin's released value so s starts at 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= INV;
                sync2_q <= INV;
                dcnt_q  <= '0;
                level_q <= 1'b0;
                hcnt_q  <= '0;
            end else begin
                sync1_q <= bus.b_in[i];
                sync2_q <= sync1_q;
                dcnt_q  <= dcnt_d;
                level_q <= level_d;
                hcnt_q  <= hcnt_d;
            end
        end

        assign s = sync2_q ^ INV;

        always_comb begin
            dcnt_d  = dcnt_q;
            level_d = level_q;
            if (s == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == D_TERM) begin
                level_d = ~level_q;
                dcnt_d  = '0;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) state_q <= RELEASED;
            else     state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            hcnt_d  = hcnt_q;
            case (state_q)
                RELEASED: begin
                    if (level_q) begin
                        state_d = PRESSED;
                        hcnt_d  = '0;
                    end
                end
                PRESSED: begin
                    if (!level_q)             state_d = RELEASED;
                    else if (hcnt_q == H_TERM) state_d = HELD;
                    else                      hcnt_d  = hcnt_q + HW'(1);
                end
                HELD: begin
                    if (!level_q) state_d = RELEASED;
                end
                default: state_d = RELEASED;
            endcase
        end

        // Events are decoded from the current level so they coincide with its edge.
        always_comb begin
            press_c   = (state_q == RELEASED) && level_q;
            release_c = (state_q != RELEASED) && !level_q;
            long_c    = (state_q == PRESSED) && level_q && (hcnt_q == H_TERM);
        end

`ifdef MULTI_BUTTON_DEBOUNCER_AUTOREPEAT_EN
        logic [RW-1:0] rcnt_q, rcnt_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) rcnt_q <= '0;
            else     rcnt_q <= rcnt_d;
        end

        always_comb begin
            rcnt_d = rcnt_q;
            if (state_q != HELD)       rcnt_d = '0;
            else if (rcnt_q == R_TERM) rcnt_d = '0;
            else                       rcnt_d = rcnt_q + RW'(1);
        end

        assign repeat_c = (state_q == HELD) && level_q && (rcnt_q == R_TERM);
`else
        assign repeat_c = 1'b0;
`endif

        assign level_w[i]   = level_q;
        assign press_w[i]   = press_c;
        assign release_w[i] = release_c;
        assign long_w[i]    = long_c;
        assign repeat_w[i]  = repeat_c;
    end

    assign bus.b_level     = level_w;
    assign bus.b_press     = press_w;
    assign bus.b_release   = release_w;
    assign bus.b_long      = long_w;
    assign bus.b_repeat    = repeat_w;
    assign bus.any_pressed = |level_w;
endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb/tb_multi_button_debouncer.sv - scoreboard bench for multi_button_debouncer
module tb_multi_button_debouncer;
    localparam int PRESS = 0, REL = 1, LONG = 2, REP = 3;

    typedef struct {
        int          cyc;
        logic [15:0] bits;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  sb[$];

    multi_button_debouncer_if #(.N(4)) bus  ();
    multi_button_debouncer_if #(.N(4)) bus2 ();

    multi_button_debouncer #(
        .N_BUTTONS(4), .STABLE_CYCLES(8), .LONG_CYCLES(32),
        .REPEAT_CYCLES(16), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    multi_button_debouncer #(
        .N_BUTTONS(4), .STABLE_CYCLES(8), .LONG_CYCLES(32),
        .REPEAT_CYCLES(16), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ev(input int c, input int kind, input logic [3:0] m);
        ev_t e;
        e.cyc  = c;
        e.bits = {12'b0, m} << (4 * kind);
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every cycle the pulse outputs must equal exactly the events due now.
    always @(negedge clk) begin
        logic [15:0] exp_v;
        logic [15:0] obs_v;
        exp_v = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                exp_v |= sb[i].bits;
                sb.delete(i);
            end
        end
        obs_v = {bus.b_repeat, bus.b_long, bus.b_release, bus.b_press};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL pulses cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        bus.b_in  = 4'hF;
        bus2.b_in = 4'hF;
        rst = 1'b1;
        step(3);
        check("rst_level", 32'(bus.b_level), 32'h0);
        check("rst_press", 32'(bus.b_press), 32'h0);
        check("rst_any", 32'(bus.any_pressed), 32'h0);

        rst = 1'b0;
        e = cyc;
        ev(e + 10, PRESS, 4'hF);
        goto(e + 9);
        check("post_rst_level_early", 32'(bus.b_level), 32'h0);
        goto(e + 10);
        check("post_rst_level", 32'(bus.b_level), 32'hF);
        check("post_rst_any", 32'(bus.any_pressed), 32'h1);
        bus.b_in = 4'h0;
        e = cyc;
        ev(e + 10, REL, 4'hF);
        goto(e + 14);
        check("all_released", 32'(bus.b_level), 32'h0);

        for (int k = 0; k < 10; k++) begin
            bus.b_in[0] = (k % 2 == 0);
            step(3);
        end
        bus.b_in[0] = 1'b1;
        e = cyc;
        ev(e + 10, PRESS, 4'h1);
        goto(e + 9);
        check("bounce_level_early", 32'(bus.b_level), 32'h0);
        goto(e + 10);
        check("bounce_level", 32'(bus.b_level), 32'h1);
        goto(e + 12);
        bus.b_in[0] = 1'b0;
        step(7);
        bus.b_in[0] = 1'b1;
        goto(e + 26);
        check("glitch7_level", 32'(bus.b_level), 32'h1);
        bus.b_in[0] = 1'b0;
        ev(cyc + 10, REL, 4'h1);
        step(12);

        bus.b_in[1] = 1'b1;
        e = cyc;
        ev(e + 10, PRESS, 4'h2);
        ev(e + 42, LONG, 4'h2);
`ifdef MULTI_BUTTON_DEBOUNCER_AUTOREPEAT_EN
        ev(e + 58, REP, 4'h2);
`endif
        goto(e + 60);
        check("long_level", 32'(bus.b_level), 32'h2);
        bus.b_in[1] = 1'b0;
        ev(e + 70, REL, 4'h2);
        goto(e + 74);
        check("long_released", 32'(bus.b_level), 32'h0);

        bus.b_in[3] = 1'b1;
        e = cyc;
        ev(e + 10, PRESS, 4'h8);
        goto(e + 12);
        check("any_ch3", 32'(bus.any_pressed), 32'h1);
        goto(e + 15);
        bus.b_in[2] = 1'b1;
        bus.b_in[3] = 1'b0;
        e = cyc;
        ev(e + 10, PRESS, 4'h4);
        ev(e + 10, REL, 4'h8);
        goto(e + 10);
        check("simul_level", 32'(bus.b_level), 32'h4);
        check("simul_any", 32'(bus.any_pressed), 32'h1);
        goto(e + 15);
        bus.b_in[2] = 1'b0;
        ev(e + 25, REL, 4'h4);
        goto(e + 26);
        check("simul_any_off", 32'(bus.any_pressed), 32'h0);

        bus2.b_in[0] = 1'b0;
        e = cyc;
        goto(e + 9);
        check("al_level_early", 32'(bus2.b_level), 32'h0);
        goto(e + 10);
        check("al_level", 32'(bus2.b_level), 32'h1);
        check("al_press", 32'(bus2.b_press), 32'h1);
        bus2.b_in[0] = 1'b1;
        step(12);
        check("al_released", 32'(bus2.b_level), 32'h0);

        bus.b_in[0] = 1'b1;
        e = cyc;
        ev(e + 10, PRESS, 4'h1);
        ev(e + 42, LONG, 4'h1);
`ifdef MULTI_BUTTON_DEBOUNCER_AUTOREPEAT_EN
        ev(e + 58, REP, 4'h1);
        ev(e + 74, REP, 4'h1);
        ev(e + 90, REP, 4'h1);
        ev(e + 106, REP, 4'h1);
`endif
        goto(e + 100);
        bus.b_in[0] = 1'b0;
        ev(e + 110, REL, 4'h1);
        goto(e + 112);
        check("hold100_released", 32'(bus.b_level), 32'h0);

        bus.b_in[1] = 1'b1;
        e = cyc;
        ev(e + 10, PRESS, 4'h2);
        goto(e + 12);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_level", 32'(bus.b_level), 32'h0);
        check("async_rst_any", 32'(bus.any_pressed), 32'h0);
        step(3);
        rst = 1'b0;
        e = cyc;
        ev(e + 10, PRESS, 4'h2);
        goto(e + 15);
        check("rst_repress_level", 32'(bus.b_level), 32'h2);
        bus.b_in[1] = 1'b0;
        ev(e + 25, REL, 4'h2);
        goto(e + 30);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
